// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with a valid/ready handshake.
// A raw IN_W-bit immediate is widened to OUT_W bits using one of four modes
// (sign, zero, upper, branch-shift). The output stage is a single result
// register backed by one skid entry. The upstream ready is therefore a pure
// function of local state and reset, so it never depends combinationally on
// the downstream ready_i. A wrap-around counter tracks delivered results.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             neg_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Reject configurations that cannot produce a meaningful extension.
    generate
        if (IN_W >= OUT_W) begin : g_bad_width
            $error("imm_extend_pipe: IN_W must be smaller than OUT_W");
        end
        if (IN_W < 2) begin : g_bad_in_w
            $error("imm_extend_pipe: IN_W must be at least 2");
        end
        if (SHL_W >= OUT_W) begin : g_bad_shift
            $error("imm_extend_pipe: SHL_W must be smaller than OUT_W");
        end
    endgenerate

    // Extension function shared by the direct load and the skid load.
    // The upper and branch modes shift an OUT_W-wide value, so bits that
    // move past OUT_W are discarded automatically.
    function automatic logic [OUT_W-1:0] extend_imm(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      mode
    );
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] zext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        zext = {{(OUT_W-IN_W){1'b0}}, imm};
        case (mode)
            MODE_SIGN:   extend_imm = sext;
            MODE_ZERO:   extend_imm = zext;
            MODE_UPPER:  extend_imm = zext << IN_W;
            MODE_BRANCH: extend_imm = sext << SHL_W;
            default:     extend_imm = sext;
        endcase
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic             out_neg_q,   out_neg_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0] count_q,     count_d;

    logic             accept_s;
    logic             deliver_s;
    logic [OUT_W-1:0] ext_s;

    // Handshake qualifiers, the extended immediate, and the upstream ready
    // (ready depends only on the skid state and reset).
    always_comb begin
        ready_o   = ~skid_valid_q & ~rst_i;
        accept_s  = valid_i & ready_o;
        deliver_s = out_valid_q & ready_i;
        ext_s     = extend_imm(data_i, mode_i);
    end

    // Next-state logic for the output register, the skid entry and the counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        count_d      = count_q;

        if (!out_valid_q || deliver_s) begin
            // Output slot is free this cycle: the older skid entry wins.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output is stalled: a new accept parks in the skid entry.
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = ext_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        if (deliver_s) begin
            count_d = count_q + CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end

        out_neg_d = out_data_d[OUT_W-1];
    end

    // State registers; reset discards any in-flight entries and clears the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_W{1'b0}};
            out_neg_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {OUT_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_neg_q    <= out_neg_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            count_q      <= count_d;
        end
    end

    // Drive the outputs straight from the registers.
    always_comb begin
        valid_o = out_valid_q;
        data_o  = out_data_q;
        neg_o   = out_neg_q;
        count_o = count_q;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe: default configuration,
// a 4-bit counter variant and a 12-to-20 bit variant sharing clock and reset.
module tb_imm_extend_pipe;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Default instance (16 -> 32, shift 2, 8-bit counter)
    logic        valid_a, ready_a_o, valid_a_o, ready_a;
    logic [15:0] data_a;
    logic [1:0]  mode_a;
    logic [31:0] data_a_o;
    logic        neg_a_o;
    logic [7:0]  count_a_o;

    // Counter-wrap instance (CNT_W = 4)
    logic        valid_b, ready_b_o, valid_b_o, ready_b;
    logic [15:0] data_b;
    logic [1:0]  mode_b;
    logic [31:0] data_b_o;
    logic        neg_b_o;
    logic [3:0]  count_b_o;

    // Narrow instance (12 -> 20, shift 1)
    logic        valid_c, ready_c_o, valid_c_o, ready_c;
    logic [11:0] data_c;
    logic [1:0]  mode_c;
    logic [19:0] data_c_o;
    logic        neg_c_o;
    logic [7:0]  count_c_o;

    imm_extend_pipe u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_a), .ready_o(ready_a_o),
        .data_i(data_a), .mode_i(mode_a), .valid_o(valid_a_o), .ready_i(ready_a),
        .data_o(data_a_o), .neg_o(neg_a_o), .count_o(count_a_o)
    );

    imm_extend_pipe #(.CNT_W(4)) u_cnt4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_b), .ready_o(ready_b_o),
        .data_i(data_b), .mode_i(mode_b), .valid_o(valid_b_o), .ready_i(ready_b),
        .data_o(data_b_o), .neg_o(neg_b_o), .count_o(count_b_o)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(20), .SHL_W(1)) u_narrow (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_c), .ready_o(ready_c_o),
        .data_i(data_c), .mode_i(mode_c), .valid_o(valid_c_o), .ready_i(ready_c),
        .data_o(data_c_o), .neg_o(neg_c_o), .count_o(count_c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_a = 1'b0; data_a = 16'h0; mode_a = 2'b00; ready_a = 1'b1;
        valid_b = 1'b0; data_b = 16'h0; mode_b = 2'b00; ready_b = 1'b1;
        valid_c = 1'b0; data_c = 12'h0; mode_c = 2'b00; ready_c = 1'b1;
        step();
        step();
        checks++; if (valid_a_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a_o); end
        checks++; if (data_a_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", data_a_o); end
        checks++; if (count_a_o !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_a_o); end
        checks++; if (ready_a_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_a_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ready_a_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", ready_a_o); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_d [4];
        logic        exp_n [4];
        exp_d[0] = 32'hFFFF8001; exp_n[0] = 1'b1;
        exp_d[1] = 32'h00008001; exp_n[1] = 1'b0;
        exp_d[2] = 32'h80010000; exp_n[2] = 1'b1;
        exp_d[3] = 32'hFFFE0004; exp_n[3] = 1'b1;
        step();
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_a = 1'b1; data_a = 16'h8001; mode_a = 2'(i);
            step();
            checks++; if (valid_a_o !== 1'b1 || data_a_o !== exp_d[i] || neg_a_o !== exp_n[i]) begin
                errors++; $display("FAIL mode%0d got v=%b d=%h n=%b want v=1 d=%h n=%b", i, valid_a_o, data_a_o, neg_a_o, exp_d[i], exp_n[i]);
            end
        end
        valid_a = 1'b0;
        step();
        checks++; if (count_a_o !== 8'd4 || valid_a_o !== 1'b0) begin
            errors++; $display("FAIL modes_count got c=%0d v=%b want c=4 v=0", count_a_o, valid_a_o);
        end
    endtask

    task automatic test_positive();
        valid_a = 1'b1; data_a = 16'h7FFF; mode_a = 2'b00;
        step();
        checks++; if (data_a_o !== 32'h00007FFF || neg_a_o !== 1'b0) begin
            errors++; $display("FAIL pos_sign got d=%h n=%b want d=00007fff n=0", data_a_o, neg_a_o);
        end
        mode_a = 2'b11;
        step();
        checks++; if (data_a_o !== 32'h0001FFFC || neg_a_o !== 1'b0) begin
            errors++; $display("FAIL pos_branch got d=%h n=%b want d=0001fffc n=0", data_a_o, neg_a_o);
        end
        valid_a = 1'b0;
        step();
        checks++; if (count_a_o !== 8'd6) begin errors++; $display("FAIL pos_count got %0d want 6", count_a_o); end
    endtask

    task automatic test_backpressure();
        ready_a = 1'b0;
        valid_a = 1'b1; mode_a = 2'b01; data_a = 16'h00A1;
        step();
        checks++; if (valid_a_o !== 1'b1 || data_a_o !== 32'h000000A1 || ready_a_o !== 1'b1) begin
            errors++; $display("FAIL bp_load_a got v=%b d=%h r=%b want v=1 d=000000a1 r=1", valid_a_o, data_a_o, ready_a_o);
        end
        data_a = 16'h00B2;
        step();
        checks++; if (ready_a_o !== 1'b0 || data_a_o !== 32'h000000A1) begin
            errors++; $display("FAIL bp_skid_full got r=%b d=%h want r=0 d=000000a1", ready_a_o, data_a_o);
        end
        data_a = 16'h00C3;
        step();
        step();
        checks++; if (ready_a_o !== 1'b0 || data_a_o !== 32'h000000A1 || valid_a_o !== 1'b1 || count_a_o !== 8'd6) begin
            errors++; $display("FAIL bp_hold got r=%b v=%b d=%h c=%0d want r=0 v=1 d=000000a1 c=6", ready_a_o, valid_a_o, data_a_o, count_a_o);
        end
        ready_a = 1'b1;
        step();
        checks++; if (data_a_o !== 32'h000000B2 || count_a_o !== 8'd7 || ready_a_o !== 1'b1) begin
            errors++; $display("FAIL bp_drain_b got d=%h c=%0d r=%b want d=000000b2 c=7 r=1", data_a_o, count_a_o, ready_a_o);
        end
        step();
        checks++; if (data_a_o !== 32'h000000C3 || count_a_o !== 8'd8 || valid_a_o !== 1'b1) begin
            errors++; $display("FAIL bp_drain_c got d=%h c=%0d v=%b want d=000000c3 c=8 v=1", data_a_o, count_a_o, valid_a_o);
        end
        valid_a = 1'b0;
        step();
        checks++; if (valid_a_o !== 1'b0 || count_a_o !== 8'd9) begin
            errors++; $display("FAIL bp_empty got v=%b c=%0d want v=0 c=9", valid_a_o, count_a_o);
        end
    endtask

    task automatic test_async_reset();
        ready_a = 1'b0;
        valid_a = 1'b1; mode_a = 2'b00; data_a = 16'h1234;
        step();
        data_a = 16'h5678;
        step();
        checks++; if (ready_a_o !== 1'b0 || valid_a_o !== 1'b1) begin
            errors++; $display("FAIL ar_full got r=%b v=%b want r=0 v=1", ready_a_o, valid_a_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_a_o !== 1'b0 || count_a_o !== 8'd0 || ready_a_o !== 1'b0 || data_a_o !== 32'h0) begin
            errors++; $display("FAIL ar_immediate got v=%b c=%0d r=%b d=%h want v=0 c=0 r=0 d=0", valid_a_o, count_a_o, ready_a_o, data_a_o);
        end
        valid_a = 1'b0;
        ready_a = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (ready_a_o !== 1'b1) begin errors++; $display("FAIL ar_release_ready got %b want 1", ready_a_o); end
        step();
        step();
        checks++; if (valid_a_o !== 1'b0 || count_a_o !== 8'd0) begin
            errors++; $display("FAIL ar_no_stale got v=%b c=%0d want v=0 c=0", valid_a_o, count_a_o);
        end
    endtask

    task automatic test_count_wrap();
        ready_b = 1'b1;
        valid_b = 1'b1; mode_b = 2'b01;
        for (int i = 0; i < 17; i++) begin
            data_b = 16'(i);
            step();
        end
        valid_b = 1'b0;
        step();
        checks++; if (count_b_o !== 4'd1 || valid_b_o !== 1'b0) begin
            errors++; $display("FAIL count_wrap got c=%0d v=%b want c=1 v=0", count_b_o, valid_b_o);
        end
    endtask

    task automatic test_narrow();
        ready_c = 1'b1;
        valid_c = 1'b1; data_c = 12'h800; mode_c = 2'b11;
        step();
        checks++; if (data_c_o !== 20'hFF000 || neg_c_o !== 1'b1) begin
            errors++; $display("FAIL narrow_branch got d=%h n=%b want d=ff000 n=1", data_c_o, neg_c_o);
        end
        mode_c = 2'b10;
        step();
        checks++; if (data_c_o !== 20'h00000 || neg_c_o !== 1'b0 || valid_c_o !== 1'b1) begin
            errors++; $display("FAIL narrow_upper got d=%h n=%b v=%b want d=00000 n=0 v=1", data_c_o, neg_c_o, valid_c_o);
        end
        valid_c = 1'b0;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_modes();
        test_positive();
        test_backpressure();
        test_async_reset();
        test_count_wrap();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
